divider_seq: RTL and testbench

Sequential unsigned divider that reverses the 8×8 multiplier datapath. It divides a 16-bit dividend by an 8-bit divisor using restoring division, one quotient bit per clock, and returns a 16-bit quotient and an 8-bit remainder. It sits beside the multiplier in the arithmetic unit and accepts one operation at a time through a start/busy/done handshake.

---
 rtl/divider_seq.sv | 130 +++++++++++++
 tb/tb_divider_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// Sequential unsigned restoring divider: 16-bit dividend / 8-bit divisor -> 16-bit quotient, 8-bit remainder.
// Latency: 16 cycles from accepted start to done (divide-by-zero result: done 1 cycle after acceptance).
// Backpressure: one operation at a time; start is ignored while busy or while a divide-by-zero result is pending.
module divider_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] vector7,
  input  logic [7:0]  vector8,
  output logic        busy,
  output logic        done,
  output logic [15:0] result3,
  output logic [7:0]  result4,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_dvd;      // dividend shifts out of the MSB, quotient bits shift into the LSB
  logic [7:0]  r_dvs;
  logic [7:0]  r_rem;      // remainder is always < divisor between iterations, so 8 bits hold it
  logic [3:0]  r_cnt;
  logic        r_zpend;    // divide-by-zero accepted last edge; result is written on the next edge
  logic [15:0] r_quo;
  logic [7:0]  r_rmd;
  logic        r_dz;

  logic        w_accept;
  logic        w_acc_nz;
  logic        w_acc_z;
  logic        w_last;
  logic [8:0]  w_part;
  logic        w_ge;
  logic [7:0]  w_sub;
  logic [7:0]  w_rem_nxt;

  // Operation acceptance is only possible outside RUN and with no zero-divisor result in flight.
  assign w_accept = start && (r_state != S_RUN) && !r_zpend;
  assign w_acc_nz = w_accept && (vector8 != 8'd0);
  assign w_acc_z  = w_accept && (vector8 == 8'd0);
  assign w_last   = (r_state == S_RUN) && (r_cnt == 4'hF);

  // The 9-bit partial remainder compare never overflows; when it succeeds the difference is
  // below the divisor, so the low 8 bits of a modular subtract are exact.
  assign w_part    = {r_rem, r_dvd[15]};
  assign w_ge      = (w_part >= {1'b0, r_dvs});
  assign w_sub     = w_part[7:0] - r_dvs;
  assign w_rem_nxt = w_ge ? w_sub : w_part[7:0];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; a zero-divisor request idles one cycle and then reports through DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_zpend) begin
          w_state_nxt = S_DONE;
        end else if (w_acc_nz) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = w_acc_nz ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, one restoring iteration per RUN cycle, result write on completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dvd   <= 16'd0;
      r_dvs   <= 8'd0;
      r_rem   <= 8'd0;
      r_cnt   <= 4'd0;
      r_zpend <= 1'b0;
      r_quo   <= 16'd0;
      r_rmd   <= 8'd0;
      r_dz    <= 1'b0;
    end else begin
      r_zpend <= w_acc_z;
      if (w_accept) begin
        r_dvd <= vector7;
        r_dvs <= vector8;
        r_rem <= 8'd0;
        r_cnt <= 4'd0;
      end else if (r_state == S_RUN) begin
        r_dvd <= {r_dvd[14:0], w_ge};
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_last) begin
        r_quo <= {r_dvd[14:0], w_ge};
        r_rmd <= w_rem_nxt;
        r_dz  <= 1'b0;
      end else if (r_zpend) begin
        r_quo <= 16'hFFFF;
        r_rmd <= r_dvd[7:0];
        r_dz  <= 1'b1;
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign result3  = r_quo;
  assign result4  = r_rmd;
  assign div_zero = r_dz;

endmodule

// File: tb/tb_divider_seq.sv
// Testbench for divider_seq: table-driven directed vectors, hand-written corner sequences, random ops.
// Latency: checks 16-cycle (or 1-cycle divide-by-zero) done timing per operation.
// Backpressure: issues operations back-to-back from the DONE cycle, and with random idle gaps.
module tb_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] vector7;
  logic [7:0]  vector8;
  logic        busy;
  logic        done;
  logic [15:0] result3;
  logic [7:0]  result4;
  logic        div_zero;

  always #5 clk = ~clk;

  divider_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .vector7  (vector7),
    .vector8  (vector8),
    .busy     (busy),
    .done     (done),
    .result3  (result3),
    .result4  (result4),
    .div_zero (div_zero)
  );

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } vec_t;

  vec_t exp_q[$];
  vec_t table_v[10];

  int   n_vec     = 0;
  int   n_err     = 0;
  int   n_done    = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pops one expectation and compares the result.
  always @(negedge clk) begin
    vec_t        e;
    logic [31:0] recon;
    if (done === 1'b1) begin
      n_done++;
      check("done_back_to_back", {31'd0, prev_done}, 32'd0);
      check("busy_with_done", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: got done with empty scoreboard at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("quotient", {16'd0, result3}, {16'd0, e.q});
        check("remainder", {24'd0, result4}, {24'd0, e.r});
        check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        if (e.dvs != 8'd0) begin
          recon = ({16'd0, result3} * {24'd0, e.dvs}) + {24'd0, result4};
          check("mul_identity", recon, {16'd0, e.dvd});
          check("rem_lt_div", {31'd0, (result4 < e.dvs)}, 32'd1);
        end
      end
    end
    prev_done = done;
  end

  // Drives one operation starting at the current negedge and waits (bounded) for its done.
  task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs);
    vec_t e;
    int   lat;
    logic saw_busy;
    e.dvd = dvd;
    e.dvs = dvs;
    if (dvs == 8'd0) begin
      e.q  = 16'hFFFF;
      e.r  = dvd[7:0];
      e.dz = 1'b1;
    end else begin
      e.q  = dvd / {8'd0, dvs};
      e.r  = 8'(dvd % {8'd0, dvs});
      e.dz = 1'b0;
    end
    exp_q.push_back(e);
    start   = 1'b1;
    vector7 = dvd;
    vector8 = dvs;
    @(negedge clk);
    start    = 1'b0;
    vector7  = 16'($urandom);
    vector8  = 8'($urandom);
    lat      = 0;
    saw_busy = busy;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    check("latency", lat, (dvs == 8'd0) ? 32'd1 : 32'd16);
    if (dvs == 8'd0) check("zero_busy", {31'd0, saw_busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_result3"}, {16'd0, result3}, 32'd0);
    check({tag, "_result4"}, {24'd0, result4}, 32'd0);
    check({tag, "_div_zero"}, {31'd0, div_zero}, 32'd0);
  endtask

  initial begin
    int         t;
    int         n0;
    logic [15:0] rd;
    logic [7:0]  rs;
    vec_t        e;

    table_v[0] = '{dvd: 16'd1000,  dvs: 8'd7,    q: 16'd142,   r: 8'd6,    dz: 1'b0};
    table_v[1] = '{dvd: 16'hFFFF,  dvs: 8'hFF,   q: 16'd257,   r: 8'd0,    dz: 1'b0};
    table_v[2] = '{dvd: 16'd5,     dvs: 8'd9,    q: 16'd0,     r: 8'd5,    dz: 1'b0};
    table_v[3] = '{dvd: 16'h1234,  dvs: 8'd0,    q: 16'hFFFF,  r: 8'h34,   dz: 1'b1};
    table_v[4] = '{dvd: 16'd10,    dvs: 8'd3,    q: 16'd3,     r: 8'd1,    dz: 1'b0};
    table_v[5] = '{dvd: 16'd0,     dvs: 8'd1,    q: 16'd0,     r: 8'd0,    dz: 1'b0};
    table_v[6] = '{dvd: 16'hFFFF,  dvs: 8'd1,    q: 16'hFFFF,  r: 8'd0,    dz: 1'b0};
    table_v[7] = '{dvd: 16'h8000,  dvs: 8'd2,    q: 16'h4000,  r: 8'd0,    dz: 1'b0};
    table_v[8] = '{dvd: 16'd200,   dvs: 8'd201,  q: 16'd0,     r: 8'd200,  dz: 1'b0};
    table_v[9] = '{dvd: 16'd65535, dvs: 8'd16,   q: 16'h0FFF,  r: 8'd15,   dz: 1'b0};

    rst_n   = 1'b0;
    start   = 1'b0;
    vector7 = 16'd0;
    vector8 = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, issued back-to-back from each DONE cycle.
    for (int i = 0; i < 10; i++) begin
      run_op(table_v[i].dvd, table_v[i].dvs);
      check("table_q", {16'd0, result3}, {16'd0, table_v[i].q});
      check("table_r", {24'd0, result4}, {24'd0, table_v[i].r});
    end
    @(negedge clk);

    // start re-pulsed mid-RUN with other operands must be ignored.
    n0 = n_done;
    e  = '{dvd: 16'd100, dvs: 8'd7, q: 16'd14, r: 8'd2, dz: 1'b0};
    exp_q.push_back(e);
    start   = 1'b1;
    vector7 = 16'd100;
    vector8 = 8'd7;
    @(negedge clk);
    start = 1'b0;
    t     = 0;
    while (done !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
      if (t == 5) begin
        start   = 1'b1;
        vector7 = 16'd50;
        vector8 = 8'd3;
      end else begin
        start = 1'b0;
      end
    end
    check("ignored_start_latency", t, 32'd16);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("ignored_start_dones", n_done - n0, 32'd1);

    // Reset in the middle of RUN aborts with no done.
    n0 = n_done;
    start   = 1'b1;
    vector7 = 16'd1000;
    vector8 = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", n_done - n0, 32'd0);
    run_op(16'd10, 8'd3);
    @(negedge clk);

    // Random operands, with divisor 1 and dividend 0 forced regularly.
    for (int i = 0; i < 1000; i++) begin
      rd = 16'($urandom);
      rs = 8'($urandom_range(1, 255));
      case ($urandom_range(0, 9))
        0: rs = 8'd1;
        1: rd = 16'd0;
        default: ;
      endcase
      run_op(rd, rs);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
